div_unit: RTL and testbench

- Multicycle restoring integer divider for MIPS div/divu.
- Sits beside the multiplier in the multicycle CPU datapath; the control FSM pulses Start with register A as dividend and register B as divisor.
- Produces quotient (Lo) and remainder (Hi), which feed the HI/LO registers through the MemParaReg write-back mux.
- Signals divide-by-zero so the controller can branch to the exception address.

---
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle restoring divider for MIPS div/divu: quotient on Lo, remainder on Hi.
// One quotient bit per cycle, with sign fix-up applied after the magnitude loop.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [2:0]       dbgState
);

  // Handshake: Start is a one-cycle request honoured only while idle (Busy=0).
  // Done is a one-cycle pulse; Lo/Hi are valid from Done until the next result.
  // Start is ignored while Busy=1. There is no back-pressure.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             sgn;
  logic             qneg;
  logic             rneg;
  logic             zeroFlag;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] dvdAbs;
  logic [WIDTH-1:0] dvsAbs;
  logic [WIDTH+1:0] rShift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] loFix;
  logic [WIDTH-1:0] hiFix;

  always_comb begin
    dvdAbs = (sgn && dvd[WIDTH-1]) ? -dvd : dvd;
    dvsAbs = (sgn && dvs[WIDTH-1]) ? -dvs : dvs;
    // Extra top bit of the trial subtraction acts as the borrow/sign.
    rShift = {r, q[WIDTH-1]};
    trial  = rShift - {2'b00, dvs};
    loFix  = qneg ? -q : q;
    hiFix  = rneg ? -r[WIDTH-1:0] : r[WIDTH-1:0];
  end

  assign dbgState = state;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      r        <= '0;
      q        <= '0;
      dvd      <= '0;
      dvs      <= '0;
      sgn      <= 1'b0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      zeroFlag <= 1'b0;
      cnt      <= '0;
      Lo       <= '0;
      Hi       <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            dvd      <= Dividendo;
            dvs      <= Divisor;
            sgn      <= Signed;
            Busy     <= 1'b1;
            zeroFlag <= (Divisor == '0);
            if (Divisor == '0) begin
              state   <= DONE;
              Done    <= 1'b1;
              DivZero <= 1'b1;
            end else begin
              state <= INIT;
            end
          end
        end
        INIT: begin
          qneg  <= sgn & (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
          rneg  <= sgn & dvd[WIDTH-1];
          r     <= '0;
          q     <= dvdAbs;
          dvs   <= dvsAbs;
          cnt   <= CNT_LAST;
          state <= ITER;
        end
        ITER: begin
          if (trial[WIDTH+1]) begin
            r <= rShift[WIDTH:0];
            q <= {q[WIDTH-2:0], 1'b0};
          end else begin
            r <= trial[WIDTH:0];
            q <= {q[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          Lo      <= loFix;
          Hi      <= hiFix;
          Done    <= 1'b1;
          DivZero <= zeroFlag;
          state   <= DONE;
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scenario tasks, expected-result queue
// filled from an arithmetic reference model, and one summary line.
module tb_div_unit;

  localparam int W = 32;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic         Signed;
  logic [W-1:0] Dividendo;
  logic [W-1:0] Divisor;
  logic [W-1:0] Lo;
  logic [W-1:0] Hi;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [2:0]   dbgState;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;
  logic [2*W:0] exp_q[$];

  div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
    .Dividendo(Dividendo), .Divisor(Divisor), .Lo(Lo), .Hi(Hi),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .dbgState(dbgState)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: {divzero, quotient, remainder}
  function automatic logic [2*W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0] qv;
    logic [W-1:0] rv;
    sa = a;
    sb = b;
    if (b == '0) return {1'b1, last_lo, last_hi};
    if (s) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == {W{1'b1}}) begin
        qv = a;
        rv = '0;
      end else begin
        qv = sa / sb;
        rv = sa % sb;
      end
    end else begin
      qv = a / b;
      rv = a % b;
    end
    return {1'b0, qv, rv};
  endfunction

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; Signed = 1'b0; Dividendo = '0; Divisor = '0;
    repeat (3) @(negedge Clk);
    cmp_cnt++;
    if ({Lo, Hi, Busy, Done, DivZero, dbgState} !== '0) begin
      bad_cnt++;
      $display("FAIL reset_state: Lo=%h Hi=%h Busy=%b Done=%b DivZero=%b st=%0d, want all zero",
               Lo, Hi, Busy, Done, DivZero, dbgState);
    end
    Reset = 1'b1;
  endtask

  // Runs one division from an idle cycle; optionally pulses a stray Start at cycle intrude_at.
  task automatic do_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int intrude_at, input string name);
    int lat;
    int exp_lat;
    logic [2*W:0] exp;
    @(negedge Clk);
    cmp_cnt++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad_cnt++;
      $display("FAIL %s_idle: Busy=%b Done=%b, want 0 0", name, Busy, Done);
    end
    exp_q.push_back(model(s, a, b));
    exp_lat = (b == '0) ? 1 : W + 3;
    Signed = s; Dividendo = a; Divisor = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < W + 10) begin
      cmp_cnt++;
      if (Busy !== 1'b1) begin
        bad_cnt++;
        $display("FAIL %s_busy: cycle %0d Busy=%b, want 1", name, lat, Busy);
      end
      if (lat == intrude_at) begin
        Start = 1'b1; Dividendo = ~a; Divisor = b + 3; Signed = ~s;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      lat++;
    end
    Start = 1'b0;
    exp = exp_q.pop_front();
    cmp_cnt++;
    if (lat !== exp_lat || Done !== 1'b1) begin
      bad_cnt++;
      $display("FAIL %s_latency: Done=%b at cycle %0d, want Done=1 at cycle %0d", name, Done, lat, exp_lat);
    end
    cmp_cnt++;
    if (Busy !== 1'b1 || DivZero !== exp[2*W]) begin
      bad_cnt++;
      $display("FAIL %s_flags: Busy=%b DivZero=%b, want 1 %b", name, Busy, DivZero, exp[2*W]);
    end
    cmp_cnt++;
    if (Lo !== exp[2*W-1:W] || Hi !== exp[W-1:0]) begin
      bad_cnt++;
      $display("FAIL %s_result: Lo=%h Hi=%h, want Lo=%h Hi=%h", name, Lo, Hi, exp[2*W-1:W], exp[W-1:0]);
    end
    if (!exp[2*W]) begin
      last_lo = exp[2*W-1:W];
      last_hi = exp[W-1:0];
    end
  endtask

  task automatic test_unsigned();
    do_div(1'b0, 32'd100, 32'd7, -1, "udiv_100_7");
    cmp_cnt++;
    if (Lo !== 32'd14 || Hi !== 32'd2) begin
      bad_cnt++;
      $display("FAIL udiv_const: Lo=%0d Hi=%0d, want 14 2", Lo, Hi);
    end
  endtask

  task automatic test_div_zero();
    do_div(1'b0, 32'd55, 32'd0, -1, "divzero");
    cmp_cnt++;
    if (Lo !== 32'd14 || Hi !== 32'd2) begin
      bad_cnt++;
      $display("FAIL divzero_hold: Lo=%0d Hi=%0d, want 14 2", Lo, Hi);
    end
  endtask

  task automatic test_signed();
    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -1, "sdiv_m7_2");
    cmp_cnt++;
    if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin
      bad_cnt++;
      $display("FAIL sdiv_m7_2_const: Lo=%h Hi=%h, want fffffffd ffffffff", Lo, Hi);
    end
    do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, -1, "sdiv_7_m2");
    cmp_cnt++;
    if (Lo !== 32'hFFFF_FFFD || Hi !== 32'h0000_0001) begin
      bad_cnt++;
      $display("FAIL sdiv_7_m2_const: Lo=%h Hi=%h, want fffffffd 00000001", Lo, Hi);
    end
    do_div(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, -1, "udiv_msb");
    cmp_cnt++;
    if (Lo !== 32'h7FFF_FFFC || Hi !== 32'h0000_0001) begin
      bad_cnt++;
      $display("FAIL udiv_msb_const: Lo=%h Hi=%h, want 7ffffffc 00000001", Lo, Hi);
    end
    do_div(1'b0, 32'h0000_0007, 32'hFFFF_FFFE, -1, "udiv_big_divisor");
  endtask

  task automatic test_overflow();
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "sdiv_overflow");
    cmp_cnt++;
    if (Lo !== 32'h8000_0000 || Hi !== 32'h0 || DivZero !== 1'b0) begin
      bad_cnt++;
      $display("FAIL overflow_const: Lo=%h Hi=%h DivZero=%b, want 80000000 0 0", Lo, Hi, DivZero);
    end
  endtask

  task automatic test_start_while_busy();
    do_div(1'b0, 32'd100, 32'd7, 5, "busy_ignore");
  endtask

  task automatic test_back_to_back();
    do_div(1'b0, 32'd50, 32'd5, -1, "b2b_50_5");
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, -1, "b2b_m100_7");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge Clk);
    Signed = 1'b0; Dividendo = 32'd100; Divisor = 32'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    cmp_cnt++;
    if (Lo !== '0 || Hi !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
      bad_cnt++;
      $display("FAIL reset_mid_clear: Lo=%h Hi=%h Busy=%b Done=%b, want 0 0 0 0", Lo, Hi, Busy, Done);
    end
    Reset = 1'b1;
    last_lo = '0;
    last_hi = '0;
    done_seen = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done === 1'b1) done_seen++;
    end
    cmp_cnt++;
    if (done_seen != 0) begin
      bad_cnt++;
      $display("FAIL reset_mid_no_done: saw %0d Done pulses, want 0", done_seen);
    end
    do_div(1'b0, 32'd9, 32'd3, -1, "after_reset_9_3");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 17));
        2: b = -W'($urandom_range(1, 17));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      do_div(s, a, b, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
